// File: rtl/vidas_ctrl.sv
// Lives and match sequencer for a two-player paddle game: tracks lives, freezes
// play after each goal, declares the winner and handles start/restart.
module vidas_ctrl #(
   parameter int LIVES        = 7,
   parameter int PAUSE_FRAMES = 60
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       frame_tick,
   input  logic       start,
   input  logic       goal_i,
   input  logic       goal_d,
   output logic [2:0] vidasi,
   output logic [2:0] vidasd,
   output logic       play,
   output logic       serve,
   output logic       game_over,
   output logic [1:0] winner
);

   // state   | meaning
   // S_IDLE  | waiting for the first start edge, lives held at LIVES
   // S_PLAY  | ball and paddles moving, goals count
   // S_PAUSE | frozen after a goal, counting frames until the next serve
   // S_OVER  | a player reached zero lives, winner latched until restart
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_PLAY  = 2'd1;
   localparam logic [1:0] S_PAUSE = 2'd2;
   localparam logic [1:0] S_OVER  = 2'd3;

   localparam logic [2:0] LIVES_INIT = 3'(LIVES);
   localparam logic [7:0] PAUSE_INIT = 8'(PAUSE_FRAMES);

   logic [1:0] state, state_nx;
   logic [7:0] pause_cnt, pause_nx;
   logic [2:0] vidasi_nx, vidasd_nx;
   logic [2:0] dec_i, dec_d;
   logic [1:0] winner_nx;
   logic       start_q;
   logic       start_edge;

   assign start_edge = start & ~start_q;
   assign dec_i      = (vidasi == 3'd0) ? 3'd0 : vidasi - 3'd1;
   assign dec_d      = (vidasd == 3'd0) ? 3'd0 : vidasd - 3'd1;

   always_comb begin
      state_nx  = state;
      pause_nx  = pause_cnt;
      vidasi_nx = vidasi;
      vidasd_nx = vidasd;
      winner_nx = winner;
      case (state)
         S_IDLE: begin
            vidasi_nx = LIVES_INIT;
            vidasd_nx = LIVES_INIT;
            if (start_edge) state_nx = S_PLAY;
         end
         S_PLAY: begin
            if (goal_i || goal_d) begin
               vidasi_nx = goal_i ? dec_i : vidasi;
               vidasd_nx = goal_d ? dec_d : vidasd;
               if ((vidasi_nx == 3'd0) || (vidasd_nx == 3'd0)) begin
                  state_nx  = S_OVER;
                  // bit1: right won (left is out), bit0: left won; both set is a draw
                  winner_nx = {vidasi_nx == 3'd0, vidasd_nx == 3'd0};
               end else begin
                  state_nx = S_PAUSE;
                  pause_nx = PAUSE_INIT;
               end
            end
         end
         S_PAUSE: begin
            if (frame_tick) begin
               pause_nx = pause_cnt - 8'd1;
               if (pause_cnt == 8'd1) state_nx = S_PLAY;
            end
         end
         S_OVER: begin
            if (start_edge) begin
               vidasi_nx = LIVES_INIT;
               vidasd_nx = LIVES_INIT;
               winner_nx = 2'b00;
               state_nx  = S_PLAY;
            end
         end
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_IDLE;
         pause_cnt <= 8'd0;
         vidasi    <= LIVES_INIT;
         vidasd    <= LIVES_INIT;
         winner    <= 2'b00;
         play      <= 1'b0;
         serve     <= 1'b0;
         game_over <= 1'b0;
         start_q   <= 1'b0;
      end else begin
         state     <= state_nx;
         pause_cnt <= pause_nx;
         vidasi    <= vidasi_nx;
         vidasd    <= vidasd_nx;
         winner    <= winner_nx;
         play      <= (state_nx == S_PLAY);
         serve     <= (state_nx == S_PLAY) && (state != S_PLAY);
         game_over <= (state_nx == S_OVER);
         start_q   <= start;
      end
   end

endmodule

// File: tb/tb_vidas_ctrl.sv
// Scenario bench for vidas_ctrl: expected output words are queued as stimulus
// is applied and compared against the registered outputs after each edge.
module tb_vidas_ctrl;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       frame_tick = 1'b0;
   logic       start = 1'b0;
   logic       goal_i = 1'b0;
   logic       goal_d = 1'b0;
   logic [2:0] vidasi, vidasd;
   logic       play, serve, game_over;
   logic [1:0] winner;

   logic [10:0] obs, got, exp_v;
   logic [10:0] sb[$];
   int n_cmp = 0;
   int n_err = 0;

   vidas_ctrl #(.LIVES(7), .PAUSE_FRAMES(60)) dut (
      .clk(clk), .reset(reset), .frame_tick(frame_tick), .start(start),
      .goal_i(goal_i), .goal_d(goal_d), .vidasi(vidasi), .vidasd(vidasd),
      .play(play), .serve(serve), .game_over(game_over), .winner(winner)
   );

   always #5 clk = ~clk;

   // word layout: {vidasi, vidasd, play, serve, game_over, winner}
   assign obs = {vidasi, vidasd, play, serve, game_over, winner};

   function automatic logic [10:0] mk(input logic [2:0] i, input logic [2:0] d,
                                      input logic p, input logic s, input logic g,
                                      input logic [1:0] w);
      return {i, d, p, s, g, w};
   endfunction

   task automatic cyc(input logic ft, input logic st, input logic gi, input logic gd);
      frame_tick = ft;
      start      = st;
      goal_i     = gi;
      goal_d     = gd;
      @(posedge clk);
      #1;
      frame_tick = 1'b0;
      goal_i     = 1'b0;
      goal_d     = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      for (int k = 0; k < 3; k++) begin
         sb.push_back(mk(3'd7, 3'd7, 1'b0, 1'b0, 1'b0, 2'b00));
         cyc(1'b1, 1'b0, 1'b1, 1'b1);
         got = obs; exp_v = sb.pop_front(); n_cmp++;
         if (got !== exp_v) begin
            n_err++; $display("FAIL reset_state cyc%0d got=%b want=%b", k, got, exp_v);
         end
      end
      reset = 1'b0;
   endtask

   task automatic test_start();
      // idle, goal in idle, start edge, start held, start released, edge in play
      logic [3:0] stim[6];
      logic [10:0] want[6];
      stim[0] = 4'b0000; want[0] = mk(3'd7, 3'd7, 1'b0, 1'b0, 1'b0, 2'b00);
      stim[1] = 4'b0010; want[1] = mk(3'd7, 3'd7, 1'b0, 1'b0, 1'b0, 2'b00);
      stim[2] = 4'b0100; want[2] = mk(3'd7, 3'd7, 1'b1, 1'b1, 1'b0, 2'b00);
      stim[3] = 4'b1100; want[3] = mk(3'd7, 3'd7, 1'b1, 1'b0, 1'b0, 2'b00);
      stim[4] = 4'b1000; want[4] = mk(3'd7, 3'd7, 1'b1, 1'b0, 1'b0, 2'b00);
      stim[5] = 4'b0100; want[5] = mk(3'd7, 3'd7, 1'b1, 1'b0, 1'b0, 2'b00);
      for (int k = 0; k < 6; k++) begin
         sb.push_back(want[k]);
         cyc(stim[k][3], stim[k][2], stim[k][1], stim[k][0]);
         got = obs; exp_v = sb.pop_front(); n_cmp++;
         if (got !== exp_v) begin
            n_err++; $display("FAIL start_seq step%0d got=%b want=%b", k, got, exp_v);
         end
      end
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   // One goal from PLAY, then a full pause: stray goals, a start edge and an
   // idle cycle inside the pause must not disturb the 60-tick countdown.
   task automatic goal_resume(input logic gi, input logic gd,
                              input logic [2:0] ei, input logic [2:0] ed);
      sb.push_back(mk(ei, ed, 1'b0, 1'b0, 1'b0, 2'b00));
      cyc(1'b0, 1'b0, gi, gd);
      got = obs; exp_v = sb.pop_front(); n_cmp++;
      if (got !== exp_v) begin
         n_err++; $display("FAIL goal_entry i=%0d d=%0d got=%b want=%b", ei, ed, got, exp_v);
      end
      for (int k = 1; k <= 60; k++) begin
         if (k == 30) begin
            sb.push_back(mk(ei, ed, 1'b0, 1'b0, 1'b0, 2'b00));
            cyc(1'b0, 1'b0, 1'b0, 1'b0);
            got = obs; exp_v = sb.pop_front(); n_cmp++;
            if (got !== exp_v) begin
               n_err++; $display("FAIL pause_no_tick got=%b want=%b", got, exp_v);
            end
         end
         sb.push_back((k < 60) ? mk(ei, ed, 1'b0, 1'b0, 1'b0, 2'b00)
                               : mk(ei, ed, 1'b1, 1'b1, 1'b0, 2'b00));
         cyc(1'b1, (k == 5), (k == 10), (k == 20));
         got = obs; exp_v = sb.pop_front(); n_cmp++;
         if (got !== exp_v) begin
            n_err++; $display("FAIL pause_tick%0d got=%b want=%b", k, got, exp_v);
         end
      end
      sb.push_back(mk(ei, ed, 1'b1, 1'b0, 1'b0, 2'b00));
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      got = obs; exp_v = sb.pop_front(); n_cmp++;
      if (got !== exp_v) begin
         n_err++; $display("FAIL serve_once got=%b want=%b", got, exp_v);
      end
   endtask

   task automatic test_single_goal();
      goal_resume(1'b1, 1'b0, 3'd6, 3'd7);
   endtask

   // Final goal into OVER, then goals, ticks and no start edge leave it frozen.
   task automatic end_game(input logic gi, input logic gd, input logic [2:0] ei,
                           input logic [2:0] ed, input logic [1:0] ew);
      for (int k = 0; k < 4; k++) begin
         sb.push_back(mk(ei, ed, 1'b0, 1'b0, 1'b1, ew));
         if (k == 0) cyc(1'b0, 1'b0, gi, gd);
         else        cyc(1'b1, 1'b0, 1'b1, 1'b1);
         got = obs; exp_v = sb.pop_front(); n_cmp++;
         if (got !== exp_v) begin
            n_err++; $display("FAIL over_w%b step%0d got=%b want=%b", ew, k, got, exp_v);
         end
      end
   endtask

   task automatic test_simultaneous();
      goal_resume(1'b0, 1'b1, 3'd6, 3'd6);
      for (int j = 5; j >= 1; j--) goal_resume(1'b1, 1'b1, 3'(j), 3'(j));
      end_game(1'b1, 1'b1, 3'd0, 3'd0, 2'b11);
   endtask

   task automatic test_restart();
      for (int k = 0; k < 4; k++) begin
         sb.push_back((k == 0) ? mk(3'd7, 3'd7, 1'b1, 1'b1, 1'b0, 2'b00)
                               : mk(3'd7, 3'd7, 1'b1, 1'b0, 1'b0, 2'b00));
         cyc(1'b0, 1'b1, 1'b0, 1'b0);
         got = obs; exp_v = sb.pop_front(); n_cmp++;
         if (got !== exp_v) begin
            n_err++; $display("FAIL restart step%0d got=%b want=%b", k, got, exp_v);
         end
      end
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_left_wins();
      for (int j = 6; j >= 1; j--) goal_resume(1'b1, 1'b1, 3'(j), 3'(j));
      end_game(1'b0, 1'b1, 3'd1, 3'd0, 2'b01);
   endtask

   task automatic test_right_wins();
      for (int j = 6; j >= 3; j--) goal_resume(1'b1, 1'b1, 3'(j), 3'(j));
      goal_resume(1'b1, 1'b0, 3'd2, 3'd3);
      goal_resume(1'b1, 1'b0, 3'd1, 3'd3);
      end_game(1'b1, 1'b0, 3'd0, 3'd3, 2'b10);
   endtask

   task automatic test_reset_in_pause();
      sb.push_back(mk(3'd6, 3'd7, 1'b0, 1'b0, 1'b0, 2'b00));
      cyc(1'b0, 1'b0, 1'b1, 1'b0);
      got = obs; exp_v = sb.pop_front(); n_cmp++;
      if (got !== exp_v) begin
         n_err++; $display("FAIL rip_goal got=%b want=%b", got, exp_v);
      end
      for (int k = 0; k < 30; k++) cyc(1'b1, 1'b0, 1'b0, 1'b0);
      reset = 1'b1;
      sb.push_back(mk(3'd7, 3'd7, 1'b0, 1'b0, 1'b0, 2'b00));
      cyc(1'b1, 1'b0, 1'b1, 1'b0);
      got = obs; exp_v = sb.pop_front(); n_cmp++;
      if (got !== exp_v) begin
         n_err++; $display("FAIL rip_reset got=%b want=%b", got, exp_v);
      end
      reset = 1'b0;
      for (int k = 0; k < 70; k++) begin
         sb.push_back(mk(3'd7, 3'd7, 1'b0, 1'b0, 1'b0, 2'b00));
         cyc(1'b1, 1'b0, 1'b0, 1'b0);
         got = obs; exp_v = sb.pop_front(); n_cmp++;
         if (got !== exp_v) begin
            n_err++; $display("FAIL rip_idle tick%0d got=%b want=%b", k, got, exp_v);
         end
      end
   endtask

   task automatic test_start_through_reset();
      reset = 1'b1;
      sb.push_back(mk(3'd7, 3'd7, 1'b0, 1'b0, 1'b0, 2'b00));
      cyc(1'b0, 1'b1, 1'b0, 1'b0);
      got = obs; exp_v = sb.pop_front(); n_cmp++;
      if (got !== exp_v) begin
         n_err++; $display("FAIL str_reset got=%b want=%b", got, exp_v);
      end
      reset = 1'b0;
      for (int k = 0; k < 3; k++) begin
         sb.push_back((k == 0) ? mk(3'd7, 3'd7, 1'b1, 1'b1, 1'b0, 2'b00)
                               : mk(3'd7, 3'd7, 1'b1, 1'b0, 1'b0, 2'b00));
         cyc(1'b0, 1'b1, 1'b0, 1'b0);
         got = obs; exp_v = sb.pop_front(); n_cmp++;
         if (got !== exp_v) begin
            n_err++; $display("FAIL str_edge step%0d got=%b want=%b", k, got, exp_v);
         end
      end
   endtask

   initial begin
      test_reset();
      test_start();
      test_single_goal();
      test_simultaneous();
      test_restart();
      test_left_wins();
      test_restart();
      test_right_wins();
      test_restart();
      test_reset_in_pause();
      test_start_through_reset();
      if (sb.size() != 0) begin
         n_err++; $display("FAIL scoreboard_leftover got=%0d want=0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/vidas_ctrl.md
VIDAS_CTRL -- requirements
Module: vidas_ctrl

Interface
REQ-001 SHALL have parameter LIVES, default 7: starting lives per player, legal range 1..7.
REQ-002 SHALL have parameter PAUSE_FRAMES, default 60: frames frozen after a goal, legal range 1..255.
REQ-003 clk  input  1  system/pixel clock; the only clock.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 frame_tick  input  1  one-cycle pulse, once per video frame.
REQ-006 start  input  1  start/restart button level; only its rising edge acts.
REQ-007 goal_i  input  1  one-cycle pulse: ball passed the left paddle, so the left player loses a life.
REQ-008 goal_d  input  1  one-cycle pulse: ball passed the right paddle, so the right player loses a life.
REQ-009 vidasi  output  3  left lives remaining; feeds the score-bar renderer.
REQ-010 vidasd  output  3  right lives remaining; feeds the score-bar renderer.
REQ-011 play  output  1  high while ball and paddle motion are enabled.
REQ-012 serve  output  1  one-cycle pulse: re-centre the ball and launch it.
REQ-013 game_over  output  1  high while in OVER.
REQ-014 winner  output  2  00 none, 01 left, 10 right, 11 draw.

Function
REQ-015 All outputs SHALL be registered; no combinational path from any input to any output.
REQ-016 SHALL implement states IDLE, PLAY, PAUSE and OVER.
REQ-017 Start edge SHALL be start=1 with start_q=0, where start_q is start registered one cycle earlier.
REQ-018 IDLE: play=0, vidasi=vidasd=LIVES; a start edge -> PLAY at the next edge.
REQ-019 On entering PLAY from any state, serve SHALL be 1 for exactly the first cycle in PLAY.
REQ-020 PLAY: play=1; goal_i sampled high -> vidasi decremented at that edge, saturating at 0; goal_d likewise for vidasd.
REQ-021 goal_i and goal_d high in the same cycle SHALL both decrement in that cycle.
REQ-022 PLAY goal resolution: if a post-decrement count is 0 -> OVER; else -> PAUSE with pause counter loaded with PAUSE_FRAMES.
REQ-023 In PLAY, play SHALL drop to 0 at the same edge that decrements a life.
REQ-024 goal_i and goal_d SHALL be ignored in IDLE, PAUSE and OVER.
REQ-025 PAUSE: play=0; the 8-bit pause counter decrements on each frame_tick.
REQ-026 PAUSE exit: counter==1 with frame_tick -> PLAY (serve per REQ-019).
REQ-027 Start edges in PLAY and PAUSE SHALL be ignored.
REQ-028 On entering OVER, game_over=1 and winner is registered as follows.
REQ-029 winner: vidasd==0 and vidasi>0 -> 01; vidasi==0 and vidasd>0 -> 10; both 0 -> 11.
REQ-030 OVER SHALL hold vidasi, vidasd and winner stable.
REQ-031 OVER exit on a start edge: at the next edge reload both counts to LIVES, clear game_over and winner to 0, go to PLAY.
REQ-032 frame_tick outside PAUSE SHALL have no effect.

Reset
REQ-033 reset=1 at a clock edge SHALL force IDLE, vidasi=vidasd=LIVES, play=0, serve=0, game_over=0, winner=00, pause counter=0, start_q=0.
REQ-034 reset SHALL override every other input, including in mid-PAUSE and OVER.
REQ-035 A start held high through reset SHALL produce one start edge on the first cycle after reset deasserts.

Verification
REQ-036 Start sequence: reset, then start 0->1 -> PLAY next cycle, serve=1 for one cycle, play=1, vidasi=vidasd=7.
REQ-037 Single goal: goal_i pulse in PLAY -> vidasi=6, play=0 at the same edge; exactly 60 frame_ticks later -> PLAY with one serve pulse.
REQ-038 Simultaneous goals: vidasi=vidasd=1, goal_i and goal_d in the same cycle -> both 0, OVER, game_over=1, winner=11.
REQ-039 Right wins: vidasi=1, vidasd=3, goal_i pulse -> vidasi=0, vidasd=3, winner=10; extra goals and frame_ticks leave all outputs unchanged.
REQ-040 Restart: in OVER, start edge -> lives=7, game_over=0, winner=00, serve pulse; start held high afterwards causes no further action.
REQ-041 Reset in PAUSE: reset asserted with the counter at 30 -> IDLE and lives=7 next cycle; subsequent frame_ticks produce no serve.
